// File: rtl/rotor_stepper_if.sv
// Handshake and position bus between the keypress source and the rotor stepper.
// The stepper drives the positions and status flags; the requester drives everything else.
interface rotor_stepper_if;
   logic       load;
   logic [4:0] load_pos_r;
   logic [4:0] load_pos_m;
   logic [4:0] load_pos_l;
   logic       key_valid;
   logic       key_ready;
   logic [4:0] pos_r;
   logic [4:0] pos_m;
   logic [4:0] pos_l;
   logic       step_done;
   logic       busy;

   modport master (
      output load, load_pos_r, load_pos_m, load_pos_l, key_valid,
      input  key_ready, pos_r, pos_m, pos_l, step_done, busy
   );

   modport slave (
      input  load, load_pos_r, load_pos_m, load_pos_l, key_valid,
      output key_ready, pos_r, pos_m, pos_l, step_done, busy
   );
endinterface

// File: rtl/rotor_stepper.sv
// Three-rotor stepping controller with notch turnover and middle-rotor double-step.
// One keypress takes three cycles: accept, step, done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a load or keypress (key_ready=1)
//   ST_STEP | step in progress; positions update on the edge leaving it
//   ST_DONE | new positions valid, step_done pulses for one cycle
module rotor_stepper #(
   parameter logic [4:0] NOTCH_R = 5'd16,
   parameter logic [4:0] NOTCH_M = 5'd4
) (
   input  logic            clk,
   input  logic            rst_n,
   rotor_stepper_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] pos_r_q, pos_r_d;
   logic [4:0] pos_m_q, pos_m_d;
   logic [4:0] pos_l_q, pos_l_d;

   // +1 modulo 26; anything at or above 25 folds to 0 so the output never leaves 0..25
   function automatic logic [4:0] adv26(input logic [4:0] p);
      return (p >= 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   function automatic logic [4:0] reduce26(input logic [4:0] p);
      return (p >= 5'd26) ? p - 5'd26 : p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pos_r_q <= 5'd0;
         pos_m_q <= 5'd0;
         pos_l_q <= 5'd0;
      end else begin
         state_q <= state_d;
         pos_r_q <= pos_r_d;
         pos_m_q <= pos_m_d;
         pos_l_q <= pos_l_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_r_d = pos_r_q;
      pos_m_d = pos_m_q;
      pos_l_d = pos_l_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               pos_r_d = reduce26(bus.load_pos_r);
               pos_m_d = reduce26(bus.load_pos_m);
               pos_l_d = reduce26(bus.load_pos_l);
            end else if (bus.key_valid) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            // All decisions use the pre-step positions; middle double-steps on its own notch
            state_d = ST_DONE;
            pos_r_d = adv26(pos_r_q);
            if ((pos_r_q == NOTCH_R) || (pos_m_q == NOTCH_M)) begin
               pos_m_d = adv26(pos_m_q);
            end
            if (pos_m_q == NOTCH_M) begin
               pos_l_d = adv26(pos_l_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.key_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.step_done = (state_q == ST_DONE);
   assign bus.pos_r     = pos_r_q;
   assign bus.pos_m     = pos_m_q;
   assign bus.pos_l     = pos_l_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: reset, stepping, notches, wrap, load reduction,
// held keypress throughput and reset during a step.
module tb_rotor_stepper;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_done;
   int   n_rdy;

   rotor_stepper_if bus ();

   rotor_stepper #(
      .NOTCH_R (5'd16),
      .NOTCH_M (5'd4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag, input logic [4:0] el, input logic [4:0] em,
                            input logic [4:0] er);
      check_eq({tag, "_l"}, 32'(bus.pos_l), 32'(el));
      check_eq({tag, "_m"}, 32'(bus.pos_m), 32'(em));
      check_eq({tag, "_r"}, 32'(bus.pos_r), 32'(er));
   endtask

   // Called at a falling edge; returns at the falling edge after the loading edge.
   task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r,
                          input logic kv);
      bus.load       = 1'b1;
      bus.load_pos_l = l;
      bus.load_pos_m = m;
      bus.load_pos_r = r;
      bus.key_valid  = kv;
      @(negedge clk);
      bus.load      = 1'b0;
      bus.key_valid = 1'b0;
   endtask

   // One keypress with the full latency profile checked; starts and ends at a falling edge.
   task automatic step_check(input string tag, input logic [4:0] el, input logic [4:0] em,
                             input logic [4:0] er);
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      check_eq({tag, "_step_busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, "_step_rdy"}, 32'(bus.key_ready), 32'd0);
      check_eq({tag, "_step_sd"}, 32'(bus.step_done), 32'd0);
      @(negedge clk);
      check_pos(tag, el, em, er);
      check_eq({tag, "_done_sd"}, 32'(bus.step_done), 32'd1);
      check_eq({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      check_eq({tag, "_idle_rdy"}, 32'(bus.key_ready), 32'd1);
      check_eq({tag, "_idle_sd"}, 32'(bus.step_done), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.load       = 1'b0;
      bus.key_valid  = 1'b0;
      bus.load_pos_l = 5'd0;
      bus.load_pos_m = 5'd0;
      bus.load_pos_r = 5'd0;

      #2;
      check_eq("rst_rdy", 32'(bus.key_ready), 32'd1);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_sd", 32'(bus.step_done), 32'd0);
      check_pos("rst", 5'd0, 5'd0, 5'd0);

      @(negedge clk);
      rst_n = 1'b1;
      step_check("basic", 5'd0, 5'd0, 5'd1);

      do_load(5'd0, 5'd3, 5'd16, 1'b0);
      check_pos("ld_notch", 5'd0, 5'd3, 5'd16);
      step_check("notch1", 5'd0, 5'd4, 5'd17);
      step_check("notch2", 5'd1, 5'd5, 5'd18);

      do_load(5'd25, 5'd4, 5'd25, 1'b0);
      step_check("wrap", 5'd0, 5'd5, 5'd0);

      do_load(5'd7, 5'd10, 5'd20, 1'b0);
      step_check("plain", 5'd7, 5'd10, 5'd21);

      do_load(5'd30, 5'd26, 5'd31, 1'b1);
      check_pos("ld_red", 5'd4, 5'd0, 5'd5);
      check_eq("ld_red_busy", 32'(bus.busy), 32'd0);
      n_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.step_done || bus.busy) n_done++;
      end
      check_eq("ld_prio_nostep", 32'(n_done), 32'd0);
      check_pos("ld_red_hold", 5'd4, 5'd0, 5'd5);

      // Held keypress: three accepted steps in nine edges
      do_load(5'd0, 5'd0, 5'd0, 1'b0);
      n_done = 0;
      n_rdy  = 0;
      bus.key_valid = 1'b1;
      repeat (9) begin
         @(negedge clk);
         if (bus.step_done) n_done++;
         if (bus.key_ready) n_rdy++;
      end
      bus.key_valid = 1'b0;
      check_eq("hold_done_cnt", 32'(n_done), 32'd3);
      check_eq("hold_rdy_cnt", 32'(n_rdy), 32'd3);
      check_pos("hold", 5'd0, 5'd0, 5'd3);
      repeat (2) @(negedge clk);
      check_pos("hold_after", 5'd0, 5'd0, 5'd3);

      // Reset while in STEP
      do_load(5'd1, 5'd2, 5'd3, 1'b0);
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_pos("rst_step", 5'd0, 5'd0, 5'd0);
      check_eq("rst_step_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_step_rdy", 32'(bus.key_ready), 32'd1);
      @(negedge clk);
      check_eq("rst_step_sd", 32'(bus.step_done), 32'd0);
      rst_n = 1'b1;
      do_load(5'd9, 5'd8, 5'd7, 1'b0);
      check_pos("ld_after_rst", 5'd9, 5'd8, 5'd7);
      @(negedge clk);
      check_eq("after_rst_sd", 32'(bus.step_done), 32'd0);

      // Reset while in DONE
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_done_sd", 32'(bus.step_done), 32'd0);
      check_eq("rst_done_busy", 32'(bus.busy), 32'd0);
      check_pos("rst_done", 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step_check("post_rst", 5'd0, 5'd0, 5'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
